// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes and controller states.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MULU = 4'h3;
    localparam logic [3:0] OP_SRL  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_SLT  = 4'h9;
    localparam logic [3:0] OP_DIVU = 4'hA;
    localparam logic [3:0] OP_SRA  = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift-add multiplier / restoring divider sharing one WIDTH+1-bit adder.
module alu_iter_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             step,
    input  logic             mode_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             div_q, div_d;

    logic [WIDTH:0]   add_a, add_b;
    logic             add_cin;
    logic [WIDTH+1:0] sum;

    // For divide the adder subtracts; sum's top bit is then the no-borrow (quotient) bit.
    always_comb begin
        if (div_q) begin
            add_a   = {acc_q, lo_q[WIDTH-1]};
            add_b   = ~{1'b0, b_q};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc_q};
            add_b   = lo_q[0] ? {1'b0, b_q} : '0;
            add_cin = 1'b0;
        end
        sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
    end

    always_comb begin
        if (div_q) begin
            if (sum[WIDTH+1]) begin
                hi_nxt = sum[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = add_a[WIDTH-1:0];
                lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign last = (cnt_q == '0);

    always_comb begin
        acc_d = acc_q;
        lo_d  = lo_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        div_d = div_q;
        if (load) begin
            acc_d = '0;
            lo_d  = a;
            b_d   = b;
            cnt_d = SHW'(WIDTH - 1);
            div_d = mode_div;
        end else if (step) begin
            acc_d = hi_nxt;
            lo_d  = lo_nxt;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            acc_q <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: START/BUSY/DONE controller, single-cycle ops and registered results/flags.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [5:0]       OPRN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] HI,
    output logic             ZERO,
    output logic             DVZ
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d, hi_q, hi_d;
    logic             zero_q, zero_d, dvz_q, dvz_d;

    logic [3:0]       op;
    logic [SHW-1:0]   shamt;
    logic             is_iter, load, step, last;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [WIDTH-1:0] sc_y, sc_hi;
    logic             sc_dvz;
    logic             unused_oprn;

    assign op          = OPRN[3:0];
    assign unused_oprn = ^OPRN[5:4];
    assign shamt       = B[SHW-1:0];
    assign is_iter     = (op == OP_MULU) || (op == OP_DIVU && B != '0);

    alu_iter_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
        .clk      (CLK),
        .srst     (RST),
        .load     (load),
        .step     (step),
        .mode_div (op == OP_DIVU),
        .a        (A),
        .b        (B),
        .last     (last),
        .hi_nxt   (it_hi),
        .lo_nxt   (it_lo)
    );

    // Divu only lands here with B == 0; mulu never does.
    always_comb begin
        sc_y   = '0;
        sc_hi  = '0;
        sc_dvz = 1'b0;
        case (op)
            OP_ADD:  sc_y = A + B;
            OP_SUB:  sc_y = A - B;
            OP_SRL:  sc_y = A >> shamt;
            OP_SLL:  sc_y = A << shamt;
            OP_AND:  sc_y = A & B;
            OP_OR:   sc_y = A | B;
            OP_NOR:  sc_y = ~(A | B);
            OP_SLT:  sc_y = ($signed(A) < $signed(B)) ? WIDTH'(1) : '0;
            OP_SRA:  sc_y = $signed(A) >>> shamt;
            OP_DIVU: begin
                sc_y   = '1;
                sc_hi  = A;
                sc_dvz = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        hi_d    = hi_q;
        zero_d  = zero_q;
        dvz_d   = dvz_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = FIN;
                    y_d     = it_lo;
                    hi_d    = it_hi;
                    zero_d  = (it_lo == '0);
                    dvz_d   = 1'b0;
                end
            end
            default: begin
                // FIN behaves as IDLE so a new request can issue on the DONE cycle.
                state_d = IDLE;
                if (START) begin
                    if (is_iter) begin
                        load    = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = FIN;
                        y_d     = sc_y;
                        hi_d    = sc_hi;
                        zero_d  = (sc_y == '0);
                        dvz_d   = sc_dvz;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            y_q     <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b0;
            dvz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            dvz_q   <= dvz_d;
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = (state_q == FIN);
    assign Y    = y_q;
    assign HI   = hi_q;
    assign ZERO = zero_q;
    assign DVZ  = dvz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=32 with hand-computed expected values.
module tb_alu_mc;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST, START;
    logic [5:0]   OPRN;
    logic [W-1:0] A, B;
    logic         BUSY, DONE, ZERO, DVZ;
    logic [W-1:0] Y, HI;

    int checks = 0;
    int errors = 0;
    int lat, busy_cnt, done_cnt;

    alu_mc #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OPRN(OPRN), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .Y(Y), .HI(HI), .ZERO(ZERO), .DVZ(DVZ)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Issue one op, then scramble operands; latency counts clock edges from START to DONE.
    task automatic run_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        OPRN = op; A = a; B = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; A = ~a; B = ~b; OPRN = 6'h3;
        lat = 1;
        busy_cnt = 0;
        while (!DONE && lat < 100) begin
            if (BUSY) busy_cnt++;
            @(posedge CLK); #1;
            lat++;
        end
        $display("op=0x%0h a=0x%08h b=0x%08h -> Y=0x%08h HI=0x%08h Z=%0d DVZ=%0d lat=%0d",
                 op, a, b, Y, HI, ZERO, DVZ, lat);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; OPRN = '0; A = '0; B = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_y", Y, 0);
        check("rst_hi", HI, 0);
        check("rst_zero", ZERO, 0);
        check("rst_dvz", DVZ, 0);
        @(negedge CLK); RST = 1'b0;

        run_op(6'h01, 32'h7FFF_FFFF, 32'h1);
        check("add_lat", lat, 1);
        check("add_busy_on_done", BUSY, 0);
        check("add_y", Y, 32'h8000_0000);
        check("add_zero", ZERO, 0);
        @(posedge CLK); #1;
        check("add_done_one_cycle", DONE, 0);
        check("add_y_hold", Y, 32'h8000_0000);

        run_op(6'h02, 32'd5, 32'd5);
        check("sub_y", Y, 0);
        check("sub_zero", ZERO, 1);

        run_op(6'h09, 32'h8000_0000, 32'h7FFF_FFFF);
        check("slt_y", Y, 1);
        run_op(6'h09, 32'h7FFF_FFFF, 32'h8000_0000);
        check("slt_swap_y", Y, 0);

        run_op(6'h03, 32'hFFFF_FFFF, 32'h2);
        check("mulu_busy_cycles", busy_cnt, 32);
        check("mulu_lat", lat, 33);
        check("mulu_y", Y, 32'hFFFF_FFFE);
        check("mulu_hi", HI, 32'h1);
        check("mulu_busy_on_done", BUSY, 0);

        run_op(6'h0A, 32'd100, 32'd7);
        check("divu_lat", lat, 33);
        check("divu_y", Y, 14);
        check("divu_hi", HI, 2);
        check("divu_dvz", DVZ, 0);
        run_op(6'h0A, 32'd100, 32'd0);
        check("dvz_lat", lat, 1);
        check("dvz_y", Y, 32'hFFFF_FFFF);
        check("dvz_hi", HI, 100);
        check("dvz_flag", DVZ, 1);
        run_op(6'h06, 32'h0000_F0F0, 32'h0000_FF00);
        check("and_y", Y, 32'h0000_F000);
        check("and_dvz_clear", DVZ, 0);

        run_op(6'h0B, 32'h8000_0000, 32'h21);
        check("sra_y", Y, 32'hC000_0000);
        run_op(6'h04, 32'h8000_0000, 32'h21);
        check("srl_y", Y, 32'h4000_0000);
        run_op(6'h05, 32'h1, 32'h24);
        check("sll_y", Y, 32'h10);
        run_op(6'h07, 32'h0000_00F0, 32'h0000_000F);
        check("or_y", Y, 32'hFF);
        run_op(6'h08, 32'h0, 32'h0);
        check("nor_y", Y, 32'hFFFF_FFFF);
        run_op(6'h0C, 32'h5, 32'h3);
        check("illegal_y", Y, 0);
        check("illegal_hi", HI, 0);
        check("illegal_zero", ZERO, 1);
        run_op(6'h31, 32'd2, 32'd3);
        check("oprn_hi_bits_ignored", Y, 5);

        // START pulses while a multiply is running must be dropped.
        @(negedge CLK);
        OPRN = 6'h03; A = 32'd3; B = 32'd5; START = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
            START = (i == 3 || i == 10 || i == 20);
            OPRN = 6'h01; A = 32'd100; B = 32'd200;
        end
        START = 1'b0;
        check("ignored_start_done_count", done_cnt, 1);
        check("ignored_start_y", Y, 15);

        // Reset at the 10th RUN cycle aborts the multiply.
        @(negedge CLK);
        OPRN = 6'h03; A = 32'd7; B = 32'd9; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        #1;
        check("abort_busy_before", BUSY, 1);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_y", Y, 0);
        check("abort_hi", HI, 0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);

        // RST and START together: START is dropped.
        @(negedge CLK);
        OPRN = 6'h01; A = 32'd1; B = 32'd1; START = 1'b1; RST = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; RST = 1'b0;
        check("rst_start_done", DONE, 0);
        @(posedge CLK); #1;
        check("rst_start_done_late", DONE, 0);
        check("rst_start_y", Y, 0);

        // Back-to-back issue on the DONE cycle.
        run_op(6'h01, 32'd1, 32'd2);
        check("b2b_first_y", Y, 3);
        OPRN = 6'h02; A = 32'd10; B = 32'd3; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("b2b_done", DONE, 1);
        check("b2b_y", Y, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
